// File: rtl/knife_spawn_scheduler.sv
// knife_spawn_scheduler
// Game-level scheduler for the falling-knife playfield. It divides the
// clock into game frames, advances the knives on unfrozen frames, turns
// spawn requests into one knife load per frame, runs the freeze power-up
// and keeps the score. All outputs come straight from registers.
module knife_spawn_scheduler #(
    parameter int TICK_DIV      = 250,
    parameter int FREEZE_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        hit,
    input  logic        freeze_req,
    input  logic        spawn_req,
    input  logic [15:0] slot_busy,
    input  logic [4:0]  lfsr,
    output logic        tick,
    output logic        spawn_valid,
    output logic [3:0]  spawn_slot,
    output logic [4:0]  spawn_col,
    output logic        spawn_drop,
    output logic        freeze_active,
    output logic [1:0]  game_state,
    output logic [9:0]  score
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW = (FREEZE_FRAMES > 0) ? $clog2(FREEZE_FRAMES + 1) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FRZ_LOAD  = FW'(FREEZE_FRAMES);
    localparam logic [9:0]    SCORE_MAX = 10'd1023;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    // Lowest-index free slot; slot 0 is preferred so the pool fills from the bottom.
    function automatic logic [3:0] first_free(input logic [15:0] busy);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (!busy[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [FW-1:0] frz_cnt_q, frz_cnt_d;
    logic          frz_act_q, frz_act_d;
    logic          pend_q, pend_d;
    logic          tick_q, tick_d;
    logic          sv_q, sv_d;
    logic [3:0]    slot_q, slot_d;
    logic [4:0]    col_q, col_d;
    logic          drop_q, drop_d;
    logic [9:0]    score_q, score_d;

    logic run_s;
    logic frame_s;
    logic end_s;
    logic svc_s;
    logic full_s;

    // Frame strobe and service qualifiers shared by the next-state logic.
    always_comb begin
        run_s   = (state_q == ST_RUN);
        frame_s = run_s && (pre_q == PRE_LAST);
        end_s   = run_s && hit;
        svc_s   = frame_s && !hit && pend_q;
        full_s  = (slot_busy == 16'hFFFF);
    end

    // Game state machine; the unused encoding falls back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (hit) state_d = ST_OVER;
                else     state_d = ST_RUN;
            end
            ST_OVER: begin
                if (start) state_d = ST_IDLE;
                else       state_d = ST_OVER;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame prescaler: counts only while running, parks at zero when the game ends.
    always_comb begin
        pre_d = pre_q;
        if (!run_s || frame_s || hit) begin
            pre_d = {PW{1'b0}};
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    // Freeze power-up: one-shot load, counts frames down, drops one clock after reaching zero.
    always_comb begin
        frz_act_d = frz_act_q;
        frz_cnt_d = frz_cnt_q;
        if (!run_s || hit) begin
            frz_act_d = 1'b0;
            frz_cnt_d = {FW{1'b0}};
        end else if (frz_act_q) begin
            if (frz_cnt_q == {FW{1'b0}}) begin
                frz_act_d = 1'b0;
            end else if (frame_s) begin
                frz_cnt_d = frz_cnt_q - FW'(1);
            end else begin
                frz_cnt_d = frz_cnt_q;
            end
        end else if (freeze_req) begin
            frz_act_d = 1'b1;
            frz_cnt_d = FRZ_LOAD;
        end else begin
            frz_act_d = frz_act_q;
        end
    end

    // Spawn pending flag: collapses all requests between frames into one service.
    always_comb begin
        pend_d = pend_q;
        if (!run_s || hit) begin
            pend_d = 1'b0;
        end else if (frame_s) begin
            // A request landing on the frame cycle itself waits for the next frame.
            pend_d = spawn_req;
        end else begin
            pend_d = pend_q | spawn_req;
        end
    end

    // Pulse outputs and the spawn payload captured on the servicing frame.
    always_comb begin
        tick_d = frame_s && !hit && !frz_act_q;
        sv_d   = svc_s && !full_s;
        drop_d = svc_s && full_s;
        if (svc_s && !full_s) begin
            slot_d = first_free(slot_busy);
            col_d  = lfsr;
        end else begin
            slot_d = slot_q;
            col_d  = col_q;
        end
    end

    // Score: cleared when a game starts, one point per advance, saturating.
    always_comb begin
        score_d = score_q;
        if ((state_q == ST_IDLE) && start) begin
            score_d = 10'd0;
        end else if (tick_q && (score_q != SCORE_MAX)) begin
            score_d = score_q + 10'd1;
        end else begin
            score_d = score_q;
        end
    end

    // State register bank with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pre_q     <= {PW{1'b0}};
            frz_cnt_q <= {FW{1'b0}};
            frz_act_q <= 1'b0;
            pend_q    <= 1'b0;
            tick_q    <= 1'b0;
            sv_q      <= 1'b0;
            slot_q    <= 4'd0;
            col_q     <= 5'd0;
            drop_q    <= 1'b0;
            score_q   <= 10'd0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            frz_cnt_q <= frz_cnt_d;
            frz_act_q <= frz_act_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            sv_q      <= sv_d;
            slot_q    <= slot_d;
            col_q     <= col_d;
            drop_q    <= drop_d;
            score_q   <= score_d;
        end
    end

    assign tick          = tick_q;
    assign spawn_valid   = sv_q;
    assign spawn_slot    = slot_q;
    assign spawn_col     = col_q;
    assign spawn_drop    = drop_q;
    assign freeze_active = frz_act_q;
    assign game_state    = state_q;
    assign score         = score_q;

endmodule

// File: tb/tb_knife_spawn_scheduler.sv
// Directed bench for knife_spawn_scheduler with TICK_DIV = 4, FREEZE_FRAMES = 2.
module tb_knife_spawn_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, hit, freeze_req, spawn_req;
    logic [15:0] slot_busy;
    logic [4:0]  lfsr;
    logic        tick, spawn_valid, spawn_drop, freeze_active;
    logic [3:0]  spawn_slot;
    logic [4:0]  spawn_col;
    logic [1:0]  game_state;
    logic [9:0]  score;
    logic [24:0] out_s;

    int n_vec  = 0;
    int n_miss = 0;
    int nv     = 0;

    typedef struct {
        logic        st, h, fr, sr;
        logic [15:0] busy;
        logic [4:0]  lf;
        logic [24:0] exp;
    } vec_t;

    vec_t vt[64];

    knife_spawn_scheduler #(.TICK_DIV(4), .FREEZE_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hit(hit),
        .freeze_req(freeze_req), .spawn_req(spawn_req),
        .slot_busy(slot_busy), .lfsr(lfsr), .tick(tick),
        .spawn_valid(spawn_valid), .spawn_slot(spawn_slot),
        .spawn_col(spawn_col), .spawn_drop(spawn_drop),
        .freeze_active(freeze_active), .game_state(game_state),
        .score(score)
    );

    always #5 clk = ~clk;

    assign out_s = {tick, spawn_valid, spawn_slot, spawn_col, spawn_drop,
                    freeze_active, game_state, score};

    // Expected-output packing: tick, valid, slot, col, drop, freeze, state, score.
    function automatic logic [24:0] pk(input logic tk, input logic sv, input logic [3:0] sl,
                                       input logic [4:0] co, input logic dr, input logic fa,
                                       input logic [1:0] gs, input logic [9:0] sc);
        return {tk, sv, sl, co, dr, fa, gs, sc};
    endfunction

    task automatic add(input logic st, input logic h, input logic fr, input logic sr,
                       input logic [15:0] busy, input logic [4:0] lf, input logic [24:0] exp);
        vt[nv].st = st; vt[nv].h = h; vt[nv].fr = fr; vt[nv].sr = sr;
        vt[nv].busy = busy; vt[nv].lf = lf; vt[nv].exp = exp;
        nv++;
    endtask

    task automatic chk(input string name, input logic [24:0] got, input logic [24:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (tick,sv,slot,col,drop,frz,state,score)",
                     name, got, exp);
        end
    endtask

    task automatic drv(input logic st, input logic h, input logic fr, input logic sr,
                       input logic [15:0] busy, input logic [4:0] lf);
        start = st; hit = h; freeze_req = fr; spawn_req = sr; slot_busy = busy; lfsr = lf;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // idle after reset
        add(0,0,0,0,16'h0000,5'd0, pk(0,0,4'd0,5'd0,0,0,2'd0,10'd0));
        // basic run: start, tick every 4 clocks, start in RUN ignored
        add(1,0,0,0,16'h0000,5'd0, pk(0,0,4'd0,5'd0,0,0,2'd1,10'd0)); // r0
        add(0,0,0,0,16'h0000,5'd0, pk(0,0,4'd0,5'd0,0,0,2'd1,10'd0));
        add(0,0,0,0,16'h0000,5'd0, pk(0,0,4'd0,5'd0,0,0,2'd1,10'd0));
        add(0,0,0,0,16'h0000,5'd0, pk(0,0,4'd0,5'd0,0,0,2'd1,10'd0));
        add(0,0,0,0,16'h0000,5'd0, pk(1,0,4'd0,5'd0,0,0,2'd1,10'd0)); // r4 frame
        add(0,0,0,0,16'h0000,5'd0, pk(0,0,4'd0,5'd0,0,0,2'd1,10'd1));
        add(1,0,0,0,16'h0000,5'd0, pk(0,0,4'd0,5'd0,0,0,2'd1,10'd1));
        add(0,0,0,0,16'h0000,5'd0, pk(0,0,4'd0,5'd0,0,0,2'd1,10'd1));
        add(0,0,0,0,16'h0000,5'd0, pk(1,0,4'd0,5'd0,0,0,2'd1,10'd1)); // r8
        add(0,0,0,0,16'h0000,5'd0, pk(0,0,4'd0,5'd0,0,0,2'd1,10'd2));
        add(0,0,0,0,16'h0000,5'd0, pk(0,0,4'd0,5'd0,0,0,2'd1,10'd2));
        add(0,0,0,0,16'h0000,5'd0, pk(0,0,4'd0,5'd0,0,0,2'd1,10'd2));
        add(0,0,0,0,16'h0000,5'd0, pk(1,0,4'd0,5'd0,0,0,2'd1,10'd2)); // r12
        add(0,0,0,0,16'h0000,5'd0, pk(0,0,4'd0,5'd0,0,0,2'd1,10'd3));
        // slot allocation: two requests, one spawn into slot 8, column 9
        add(0,0,0,1,16'h00FF,5'd9, pk(0,0,4'd0,5'd0,0,0,2'd1,10'd3)); // r14
        add(0,0,0,1,16'h00FF,5'd9, pk(0,0,4'd0,5'd0,0,0,2'd1,10'd3));
        add(0,0,0,0,16'h00FF,5'd9, pk(1,1,4'd8,5'd9,0,0,2'd1,10'd3)); // r16 frame
        add(0,0,0,0,16'h00FF,5'd3, pk(0,0,4'd8,5'd9,0,0,2'd1,10'd4));
        add(0,0,0,0,16'h00FF,5'd3, pk(0,0,4'd8,5'd9,0,0,2'd1,10'd4));
        add(0,0,0,0,16'h00FF,5'd3, pk(0,0,4'd8,5'd9,0,0,2'd1,10'd4));
        add(0,0,0,0,16'h00FF,5'd3, pk(1,0,4'd8,5'd9,0,0,2'd1,10'd4)); // r20 no second spawn
        // pool full: drop instead of spawn
        add(0,0,0,0,16'hFFFF,5'd3, pk(0,0,4'd8,5'd9,0,0,2'd1,10'd5));
        add(0,0,0,1,16'hFFFF,5'd3, pk(0,0,4'd8,5'd9,0,0,2'd1,10'd5));
        add(0,0,0,0,16'hFFFF,5'd3, pk(0,0,4'd8,5'd9,0,0,2'd1,10'd5));
        add(0,0,0,0,16'hFFFF,5'd3, pk(1,0,4'd8,5'd9,1,0,2'd1,10'd5)); // r24
        add(0,0,0,0,16'hFFFF,5'd3, pk(0,0,4'd8,5'd9,0,0,2'd1,10'd6));
        add(0,0,0,0,16'hFFFF,5'd3, pk(0,0,4'd8,5'd9,0,0,2'd1,10'd6));
        add(0,0,0,0,16'hFFFF,5'd3, pk(0,0,4'd8,5'd9,0,0,2'd1,10'd6));
        add(0,0,0,0,16'hFFFF,5'd3, pk(1,0,4'd8,5'd9,0,0,2'd1,10'd6)); // r28
        add(0,0,0,0,16'h0000,5'd5, pk(0,0,4'd8,5'd9,0,0,2'd1,10'd7));
        // freeze for two frames; spawn still issued; retrigger ignored
        add(0,0,1,1,16'h0000,5'd5, pk(0,0,4'd8,5'd9,0,1,2'd1,10'd7)); // r30
        add(0,0,0,0,16'h0000,5'd5, pk(0,0,4'd8,5'd9,0,1,2'd1,10'd7));
        add(0,0,0,0,16'h0000,5'd5, pk(0,1,4'd0,5'd5,0,1,2'd1,10'd7)); // r32 frozen frame 1
        add(0,0,1,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,1,2'd1,10'd7));
        add(0,0,0,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,1,2'd1,10'd7));
        add(0,0,0,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,1,2'd1,10'd7));
        add(0,0,0,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,1,2'd1,10'd7)); // r36 frozen frame 2
        add(0,0,0,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,0,2'd1,10'd7));
        add(0,0,0,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,0,2'd1,10'd7));
        add(0,0,0,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,0,2'd1,10'd7));
        add(0,0,0,0,16'h0000,5'd5, pk(1,0,4'd0,5'd5,0,0,2'd1,10'd7)); // r40 ticks resume
        add(0,0,0,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,0,2'd1,10'd8));
        // hit on the frame cycle with a spawn pending
        add(0,0,0,1,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,0,2'd1,10'd8)); // r42
        add(0,0,0,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,0,2'd1,10'd8));
        add(0,1,0,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,0,2'd2,10'd8)); // r44
        add(0,0,0,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,0,2'd2,10'd8));
        add(1,0,0,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,0,2'd0,10'd8));
        add(1,0,0,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,0,2'd1,10'd0)); // r47 restart
        add(0,0,0,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,0,2'd1,10'd0));
        add(0,0,0,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,0,2'd1,10'd0));
        add(0,0,0,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,0,2'd1,10'd0));
        add(0,0,0,0,16'h0000,5'd5, pk(1,0,4'd0,5'd5,0,0,2'd1,10'd0)); // r51 no stale spawn
        add(0,0,0,0,16'h0000,5'd5, pk(0,0,4'd0,5'd5,0,0,2'd1,10'd1));

        // reset applied asynchronously at time zero
        rst_n = 1'b0;
        drv(0,0,0,0,16'h0000,5'd0);
        #1;
        chk("reset_async", out_s, 25'd0);
        step();
        step();
        rst_n = 1'b1;
        chk("reset_held", out_s, 25'd0);

        for (int i = 0; i < nv; i++) begin
            drv(vt[i].st, vt[i].h, vt[i].fr, vt[i].sr, vt[i].busy, vt[i].lf);
            step();
            chk($sformatf("vec%0d", i), out_s, vt[i].exp);
        end

        // run on to score saturation
        drv(0,0,0,0,16'h0000,5'd0);
        for (int k = 0; k < 4500 && score != 10'd1023; k++) begin
            step();
        end
        chk("score_reach_1023", {15'd0, score}, {15'd0, 10'd1023});
        for (int k = 0; k < 9; k++) begin
            step();
        end
        chk("score_saturated", {15'd0, score}, {15'd0, 10'd1023});
        chk("still_running", {23'd0, game_state}, {23'd0, 2'd1});

        // freeze, then reset mid-freeze
        freeze_req = 1'b1;
        step();
        freeze_req = 1'b0;
        chk("freeze_on", {24'd0, freeze_active}, 25'd1);
        step();
        step();
        chk("freeze_mid", {24'd0, freeze_active}, 25'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_midfreeze_async", out_s, 25'd0);
        step();
        rst_n = 1'b1;
        chk("reset_midfreeze_held", out_s, 25'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("post_reset_idle%0d", k), out_s, 25'd0);
        end

        // reset on the cycle just before a tick pulse
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_run", {23'd0, game_state}, {23'd0, 2'd1});
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_pre_tick_async", out_s, 25'd0);
        step();
        chk("reset_pre_tick_edge", out_s, 25'd0);
        rst_n = 1'b1;
        step();
        chk("reset_pre_tick_after", out_s, 25'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
